// File: rtl/branch_pc_sequencer.sv
// Next-PC engine: owns the PC, issues fetches, resolves branches/jumps from ALU flags and halts on faults.
// Optional saturating branch counters are enabled by defining BRANCH_STATS_EN.
`timescale 1ns/1ps
module branch_pc_sequencer #(
   parameter int unsigned      WIDTH    = 32,
   parameter logic [WIDTH-1:0] RESET_PC = 32'h8000_0000
) (
   input  logic             clk,
   input  logic             rst_n,
   output logic             fetch_valid,
   output logic [WIDTH-1:0] fetch_pc,
   input  logic             fetch_ready,
   input  logic             exec_valid,
   output logic             exec_ready,
   input  logic [1:0]       exec_kind,
   input  logic [2:0]       exec_funct3,
   input  logic [WIDTH-1:0] exec_target,
   output logic             CompUn,
   input  logic             BrEq,
   input  logic             BrLT,
   output logic             redirect,
   output logic             halted,
   output logic [1:0]       halt_cause
`ifdef BRANCH_STATS_EN
   ,
   output logic [31:0]      taken_cnt,
   output logic [31:0]      ntaken_cnt
`endif
);

   typedef enum logic [1:0] {
      S_FETCH = 2'b00,
      S_EXEC  = 2'b01,
      S_HALT  = 2'b10
   } state_t;

   localparam logic [1:0]       KIND_SEQ   = 2'b00;
   localparam logic [1:0]       KIND_BR    = 2'b01;
   localparam logic [1:0]       KIND_JAL   = 2'b10;
   localparam logic [1:0]       KIND_JALR  = 2'b11;
   localparam logic [1:0]       CAUSE_NONE = 2'b00;
   localparam logic [1:0]       CAUSE_MIS  = 2'b01;
   localparam logic [1:0]       CAUSE_ILL  = 2'b10;
   localparam logic [WIDTH-1:0] PC_STEP    = {{(WIDTH-3){1'b0}}, 3'b100};

   state_t           state_r;
   logic [WIDTH-1:0] pc_r;
   logic             taken_s;
   logic             illegal_s;
   logic             misalign_s;
   logic [WIDTH-1:0] seq_pc_s;
   logic [WIDTH-1:0] jump_tgt_s;
   logic [WIDTH-1:0] next_s;

   // The ALU picks signed/unsigned compare straight from the branch encoding.
   assign CompUn   = exec_funct3[1];
   assign fetch_pc = pc_r;

   // Branch/jump taken decision and illegal-encoding detect.
   always_comb begin
      taken_s   = 1'b0;
      illegal_s = 1'b0;
      case (exec_kind)
         KIND_SEQ: taken_s = 1'b0;
         KIND_BR: begin
            case (exec_funct3)
               3'b000:         taken_s = BrEq;
               3'b001:         taken_s = !BrEq;
               3'b100, 3'b110: taken_s = BrLT;
               3'b101, 3'b111: taken_s = !BrLT;
               default:        illegal_s = 1'b1;
            endcase
         end
         KIND_JAL, KIND_JALR: taken_s = 1'b1;
         default: taken_s = 1'b0;
      endcase
   end

   // Next-PC selection; JALR drops bit 0 before the alignment check.
   always_comb begin
      seq_pc_s   = pc_r + PC_STEP;
      jump_tgt_s = exec_target;
      next_s     = seq_pc_s;
      if (exec_kind == KIND_JALR) begin
         jump_tgt_s = {exec_target[WIDTH-1:1], 1'b0};
      end else begin
         jump_tgt_s = exec_target;
      end
      if (taken_s) begin
         next_s = jump_tgt_s;
      end else begin
         next_s = seq_pc_s;
      end
      misalign_s = taken_s && (next_s[1:0] != 2'b00);
   end

   // Sequencer FSM with registered handshake and status outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r     <= S_FETCH;
         pc_r        <= RESET_PC;
         fetch_valid <= 1'b1;
         exec_ready  <= 1'b0;
         redirect    <= 1'b0;
         halted      <= 1'b0;
         halt_cause  <= CAUSE_NONE;
      end else begin
         redirect <= 1'b0;
         case (state_r)
            S_FETCH: begin
               if (fetch_ready) begin
                  state_r     <= S_EXEC;
                  fetch_valid <= 1'b0;
                  exec_ready  <= 1'b1;
               end
            end
            S_EXEC: begin
               if (exec_valid) begin
                  exec_ready <= 1'b0;
                  if (misalign_s) begin
                     state_r    <= S_HALT;
                     halted     <= 1'b1;
                     halt_cause <= CAUSE_MIS;
                  end else if (illegal_s) begin
                     state_r    <= S_HALT;
                     halted     <= 1'b1;
                     halt_cause <= CAUSE_ILL;
                  end else begin
                     state_r     <= S_FETCH;
                     pc_r        <= next_s;
                     fetch_valid <= 1'b1;
                     redirect    <= taken_s;
                  end
               end
            end
            S_HALT: begin
               fetch_valid <= 1'b0;
               exec_ready  <= 1'b0;
               halted      <= 1'b1;
            end
            default: begin
               // A corrupted state code parks the core rather than guessing a PC.
               state_r     <= S_HALT;
               fetch_valid <= 1'b0;
               exec_ready  <= 1'b0;
               halted      <= 1'b1;
            end
         endcase
      end
   end

`ifdef BRANCH_STATS_EN
   logic count_s;

   assign count_s = (state_r == S_EXEC) && exec_valid && (exec_kind == KIND_BR)
                    && !illegal_s && !misalign_s;

   // Saturating taken / not-taken counters for retired conditional branches.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         taken_cnt  <= 32'h0000_0000;
         ntaken_cnt <= 32'h0000_0000;
      end else if (count_s) begin
         if (taken_s) begin
            if (taken_cnt != 32'hFFFF_FFFF) taken_cnt <= taken_cnt + 32'd1;
         end else begin
            if (ntaken_cnt != 32'hFFFF_FFFF) ntaken_cnt <= ntaken_cnt + 32'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_branch_pc_sequencer.sv
// Scoreboard bench: the driver pushes expected fetch/halt events from a branch-semantics model,
// a monitor pops and compares them as the sequencer presents fetches or halts.
`timescale 1ns/1ps
module tb_branch_pc_sequencer;
   localparam logic [31:0] RESET_PC = 32'h8000_0000;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        fetch_valid;
   logic [31:0] fetch_pc;
   logic        fetch_ready;
   logic        exec_valid;
   logic        exec_ready;
   logic [1:0]  exec_kind;
   logic [2:0]  exec_funct3;
   logic [31:0] exec_target;
   logic        CompUn;
   logic        BrEq;
   logic        BrLT;
   logic        redirect;
   logic        halted;
   logic [1:0]  halt_cause;
`ifdef BRANCH_STATS_EN
   logic [31:0] taken_cnt;
   logic [31:0] ntaken_cnt;
`endif

   always #5 clk = ~clk;

   branch_pc_sequencer #(.WIDTH(32), .RESET_PC(RESET_PC)) dut (
      .clk(clk), .rst_n(rst_n),
      .fetch_valid(fetch_valid), .fetch_pc(fetch_pc), .fetch_ready(fetch_ready),
      .exec_valid(exec_valid), .exec_ready(exec_ready), .exec_kind(exec_kind),
      .exec_funct3(exec_funct3), .exec_target(exec_target), .CompUn(CompUn),
      .BrEq(BrEq), .BrLT(BrLT), .redirect(redirect), .halted(halted),
      .halt_cause(halt_cause)
`ifdef BRANCH_STATS_EN
      , .taken_cnt(taken_cnt), .ntaken_cnt(ntaken_cnt)
`endif
   );

   typedef struct {
      bit          is_halt;
      logic [31:0] pc;
      logic        redir;
      logic [1:0]  cause;
   } exp_t;

   exp_t        q[$];
   exp_t        mon_item;
   int          checks = 0;
   int          errors = 0;
   bit          mon_en = 1'b0;
   bit          prev_fv, prev_halt, prev_hs;
   logic [31:0] held_pc;
   logic [31:0] m_pc;
   bit          m_halt;
   logic [1:0]  m_cause;
   int          m_tk, m_nt;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   task automatic sb_empty_fail(input string name);
      checks++;
      errors++;
      $display("FAIL %s actual=output_seen required=no_output_expected", name);
   endtask

   task automatic junk();
      exec_kind   = 2'($urandom_range(3, 0));
      exec_funct3 = 3'($urandom_range(7, 0));
      exec_target = $urandom();
      BrEq        = 1'($urandom_range(1, 0));
      BrLT        = 1'($urandom_range(1, 0));
   endtask

   // Reference: RISC-V branch semantics evaluated on the operands themselves.
   task automatic model_exec(input logic [1:0] kind, input logic [2:0] f3,
                             input logic [31:0] tgt, input logic [31:0] a, input logic [31:0] b);
      bit          tk, ill;
      logic [31:0] dest;
      tk  = 1'b0;
      ill = 1'b0;
      if (kind == 2'd1) begin
         case (f3)
            3'd0: tk = (a == b);
            3'd1: tk = (a != b);
            3'd4: tk = ($signed(a) <  $signed(b));
            3'd5: tk = ($signed(a) >= $signed(b));
            3'd6: tk = (a <  b);
            3'd7: tk = (a >= b);
            default: ill = 1'b1;
         endcase
      end else begin
         tk = (kind != 2'd0);
      end
      dest = (kind == 2'd3) ? (tgt & 32'hFFFF_FFFE) : tgt;
      if (ill) begin
         m_halt = 1'b1; m_cause = 2'b10;
         q.push_back('{is_halt: 1'b1, pc: 32'h0, redir: 1'b0, cause: 2'b10});
      end else if (tk && (dest % 32'd4 != 32'd0)) begin
         m_halt = 1'b1; m_cause = 2'b01;
         q.push_back('{is_halt: 1'b1, pc: 32'h0, redir: 1'b0, cause: 2'b01});
      end else begin
         if (kind == 2'd1) begin
            if (tk) m_tk++; else m_nt++;
         end
         m_pc = tk ? dest : m_pc + 32'd4;
         q.push_back('{is_halt: 1'b0, pc: m_pc, redir: tk, cause: 2'b00});
      end
   endtask

   task automatic do_reset();
      mon_en      = 1'b0;
      rst_n       = 1'b0;
      q.delete();
      fetch_ready = 1'b0;
      exec_valid  = 1'b0;
      #1;
      check("reset_values", {fetch_valid, exec_ready, redirect, halted, halt_cause, fetch_pc},
            {1'b1, 1'b0, 1'b0, 1'b0, 2'b00, RESET_PC});
      repeat (2) @(posedge clk);
      #1;
      m_pc = RESET_PC; m_halt = 1'b0; m_cause = 2'b00; m_tk = 0; m_nt = 0;
      q.push_back('{is_halt: 1'b0, pc: RESET_PC, redir: 1'b0, cause: 2'b00});
      rst_n  = 1'b1;
      mon_en = 1'b1;
   endtask

   task automatic fetch_handshake(input int stall);
      int n;
      for (int s = 0; s < stall; s++) begin
         fetch_ready = 1'b0;
         exec_valid  = 1'($urandom_range(1, 0));
         junk();
         @(posedge clk); #1;
      end
      fetch_ready = 1'b1;
      exec_valid  = 1'($urandom_range(1, 0));
      junk();
      n = 0;
      while (!fetch_valid && n < 20) begin
         @(posedge clk); #1;
         n++;
      end
      check("fetch_valid_wait", fetch_valid, 1'b1);
      @(posedge clk); #1;
      fetch_ready = 1'b0;
      exec_valid  = 1'b0;
   endtask

   task automatic exec_txn(input logic [1:0] kind, input logic [2:0] f3, input logic [31:0] tgt,
                           input logic [31:0] a, input logic [31:0] b, input int dly);
      int n;
      for (int d = 0; d < dly; d++) begin
         exec_valid = 1'b0;
         junk();
         @(posedge clk); #1;
      end
      n = 0;
      while (!exec_ready && n < 20) begin
         @(posedge clk); #1;
         n++;
      end
      check("exec_ready_wait", exec_ready, 1'b1);
      exec_kind   = kind;
      exec_funct3 = f3;
      exec_target = tgt;
      BrEq        = (a == b);
      BrLT        = f3[1] ? (a < b) : ($signed(a) < $signed(b));
      exec_valid  = 1'b1;
      #1;
      check("compun", CompUn, f3[1]);
      model_exec(kind, f3, tgt, a, b);
      @(posedge clk); #1;
      exec_valid = 1'b0;
      junk();
   endtask

   task automatic finish_episode();
      for (int c = 0; c < 4; c++) begin
         fetch_ready = m_halt ? 1'($urandom_range(1, 0)) : 1'b0;
         exec_valid  = m_halt ? 1'($urandom_range(1, 0)) : 1'b0;
         junk();
         @(posedge clk); #1;
      end
      fetch_ready = 1'b0;
      exec_valid  = 1'b0;
      if (m_halt) begin
         check("halt_absorb", {halted, halt_cause, fetch_valid, exec_ready, redirect},
               {1'b1, m_cause, 3'b000});
      end
      check("sb_drain", q.size(), 0);
`ifdef BRANCH_STATS_EN
      check("taken_cnt", taken_cnt, m_tk);
      check("ntaken_cnt", ntaken_cnt, m_nt);
`endif
   endtask

   task automatic run_random(input int n);
      logic [31:0] t, a, b;
      logic [1:0]  k;
      logic [2:0]  f;
      int          r;
      for (int i = 0; i < n; i++) begin
         if (!m_halt) begin
            fetch_handshake($urandom_range(3, 0));
            k = 2'($urandom_range(3, 0));
            f = 3'($urandom_range(7, 0));
            t = $urandom();
            r = $urandom_range(15, 0);
            if (r < 12)                 t[1:0] = 2'b00;
            else if (r == 12 || r == 15) t[1:0] = 2'b01;
            else if (r == 13)           t[1:0] = 2'b10;
            else                        t[1:0] = 2'b11;
            a = $urandom();
            b = ($urandom_range(3, 0) == 0) ? a : $urandom();
            exec_txn(k, f, t, a, b, $urandom_range(2, 0));
         end
      end
      finish_episode();
   endtask

   initial begin
      fetch_ready = 1'b0;
      exec_valid  = 1'b0;
      junk();
      fork
         forever begin
            @(negedge clk);
            if (!mon_en) begin
               prev_fv = 1'b0; prev_halt = 1'b0; prev_hs = 1'b0;
            end else begin
               if (prev_hs) check("fetch_to_exec", {exec_ready, fetch_valid, redirect}, 3'b100);
               if (fetch_valid && !prev_fv) begin
                  if (q.size() == 0) sb_empty_fail("sb_fetch_unexpected");
                  else begin
                     mon_item = q.pop_front();
                     check("event_is_fetch", mon_item.is_halt, 1'b0);
                     check("fetch_pc_redirect", {redirect, fetch_pc}, {mon_item.redir, mon_item.pc});
                     held_pc = mon_item.pc;
                  end
               end else if (fetch_valid) begin
                  check("fetch_hold", {redirect, fetch_pc}, {1'b0, held_pc});
               end
               if (halted && !prev_halt) begin
                  if (q.size() == 0) sb_empty_fail("sb_halt_unexpected");
                  else begin
                     mon_item = q.pop_front();
                     check("event_is_halt", mon_item.is_halt, 1'b1);
                     check("halt_outputs", {halt_cause, fetch_valid, exec_ready, redirect},
                           {mon_item.cause, 3'b000});
                  end
               end
               prev_fv   = fetch_valid;
               prev_halt = halted;
               prev_hs   = fetch_valid && fetch_ready;
            end
         end
      join_none

      #1;
      // Directed walk: sequential, BLTU, BNE/BGE/BEQ/BLT, JALR, wrap, then misaligned JAL.
      do_reset();
      fetch_handshake(0); exec_txn(2'd0, 3'd0, 32'h0000_0000, 32'd0, 32'd0, 0);
      fetch_handshake(2); exec_txn(2'd2, 3'd0, 32'h8000_0010, 32'd0, 32'd0, 0);
      fetch_handshake(0); exec_txn(2'd1, 3'd6, 32'h8000_0040, 32'd1, 32'd2, 1);
      fetch_handshake(1); exec_txn(2'd1, 3'd1, 32'h8000_0090, 32'd7, 32'd7, 0);
      fetch_handshake(0); exec_txn(2'd1, 3'd5, 32'h8000_0080, 32'd5, 32'd3, 0);
      fetch_handshake(0); exec_txn(2'd1, 3'd0, 32'h8000_00C0, 32'd9, 32'd9, 0);
      fetch_handshake(0); exec_txn(2'd1, 3'd4, 32'h8000_0000, 32'd5, 32'd3, 0);
      fetch_handshake(0); exec_txn(2'd1, 3'd4, 32'h8000_0200, 32'hFFFF_FFFF, 32'd1, 0);
      fetch_handshake(0); exec_txn(2'd3, 3'd0, 32'h8000_0101, 32'd0, 32'd0, 0);
      fetch_handshake(0); exec_txn(2'd2, 3'd0, 32'hFFFF_FFFC, 32'd0, 32'd0, 0);
      fetch_handshake(0); exec_txn(2'd0, 3'd0, 32'h0000_0000, 32'd0, 32'd0, 0);
      fetch_handshake(0); exec_txn(2'd2, 3'd0, 32'h8000_0102, 32'd0, 32'd0, 0);
      finish_episode();

      do_reset();
      fetch_handshake(0); exec_txn(2'd1, 3'd2, 32'h8000_0040, 32'd1, 32'd1, 0);
      finish_episode();

      // Long fetch stall, then reset asserted between clock edges during a stall.
      do_reset();
      fetch_handshake(5); exec_txn(2'd2, 3'd0, 32'h1234_5670, 32'd0, 32'd0, 1);
      fetch_ready = 1'b0;
      repeat (3) @(posedge clk);
      #2;
      do_reset();
      fetch_handshake(1); exec_txn(2'd0, 3'd0, 32'h0000_0000, 32'd0, 32'd0, 0);
      finish_episode();

      for (int e = 0; e < 25; e++) begin
         do_reset();
         run_random(30);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/branch_pc_sequencer.md
# branch_pc_sequencer

Sequential next-PC engine for the NPC core. It owns the architectural PC and issues fetch requests to the IFU over a valid/ready handshake. It accepts one execute-stage result per instruction, drives the ALU's `CompUn` select, and resolves branches/jumps from the ALU's `BrEq`/`BrLT` flags and adder sum. It halts the core on a misaligned target or an illegal branch encoding.

## Interface
- `WIDTH`, 32, datapath/PC width
- `RESET_PC`, 32'h8000_0000, first fetch address after reset

- `clk`  in  1  system clock, all state on rising edge
- `rst_n`  in  1  reset, asynchronous, active-low
- `fetch_valid`  out  1  fetch request valid
- `fetch_pc`  out  WIDTH  fetch address, stable while `fetch_valid` is high
- `fetch_ready`  in  1  IFU accepts request
- `exec_valid`  in  1  execute result valid
- `exec_ready`  out  1  sequencer accepts execute result
- `exec_kind`  in  2  00 sequential, 01 conditional branch, 10 JAL, 11 JALR
- `exec_funct3`  in  3  branch funct3
- `exec_target`  in  WIDTH  ALU adder sum: pc+imm for branch/JAL, rs1+imm for JALR
- `CompUn`  out  1  to ALU; combinational, equals `exec_funct3[1]`
- `BrEq`, `BrLT`  in  1 each  ALU compare flags for the current execute result
- `redirect`  out  1  one-cycle pulse when a taken branch or jump is accepted
- `halted`  out  1  high in HALT
- `halt_cause`  out  2  00 none, 01 misaligned target, 10 illegal funct3

## Operation
- States: FETCH, EXEC, HALT. Reset enters FETCH with `pc`=`RESET_PC`.
- FETCH: `fetch_valid`=1, `fetch_pc`=`pc`, `exec_ready`=0. On `fetch_valid & fetch_ready`, go to EXEC.
- EXEC: `fetch_valid`=0, `exec_ready`=1. On `exec_valid`, compute `next` and check it:
  - Target check: if taken and `next[1:0]`≠0, go to HALT with cause 01 and leave `pc` unchanged.
  - Illegal branch: if `exec_kind`=01 and funct3 ∈ {010, 011}, go to HALT with cause 10.
  - Otherwise `pc`←`next` and go to FETCH.
- Taken condition for kind 01:
  - 000: `BrEq`
  - 001: `!BrEq`
  - 100 and 110: `BrLT`
  - 101 and 111: `!BrLT`
- `next`:
  - kind 00, or branch not taken: `pc`+4 (mod 2^WIDTH, wraps silently)
  - taken branch or JAL: `exec_target`
  - JALR: `exec_target` with bit 0 cleared before the alignment check
- `redirect` is registered and high for exactly the cycle after a taken/jump acceptance. It is never asserted on a halting acceptance.
- HALT is absorbing until reset. All handshake outputs are 0. `halted`=1 and `halt_cause` is held.
- Inputs `exec_*` and the ALU flags are ignored outside EXEC.

## Timing
- Reset values: `fetch_valid`=1 (state FETCH), `fetch_pc`=`RESET_PC`, `exec_ready`=0, `redirect`=0, `halted`=0, `halt_cause`=00.
- Latency:
  - Fetch handshake to `exec_ready`: 1 cycle.
  - Exec handshake to `fetch_valid` with the new PC: 1 cycle.
- `fetch_valid` is never dropped before `fetch_ready`. `fetch_pc` is held while stalled.
- Same-cycle `exec_valid` with `fetch_ready` cannot conflict, since the states are exclusive.
- `rst_n` low mid-transaction immediately forces the reset values. Any in-flight handshake is discarded.
- `CompUn` is purely combinational and valid within the same cycle that `BrLT` is sampled.

## Configuration
- `BRANCH_STATS_EN` defined:
  - Adds outputs `taken_cnt` and `ntaken_cnt` (32 bits each, reset 0).
  - They increment on accepted kind-01 results, taken and not-taken respectively, and saturate at 32'hFFFF_FFFF.
  - Halting acceptances are not counted.
- Not defined: the ports and counters are absent; all other behaviour is identical.

## Test plan
- Reset release with `fetch_ready`=1 → `fetch_pc`=0x8000_0000 accepted at cycle 1; a kind-00 exec then gives next `fetch_pc`=0x8000_0004 and `redirect`=0.
- BLTU (funct3 110) at `pc`=0x8000_0010, `exec_target`=0x8000_0040, `BrLT`=1 → `CompUn`=1, `redirect` pulses once, next `fetch_pc`=0x8000_0040.
- BNE with `BrEq`=1 → not taken, `fetch_pc`=`pc`+4, `redirect`=0. BGE with `BrLT`=0 → taken.
- JALR with `exec_target`=0x8000_0101 → `fetch_pc`=0x8000_0100. JAL with target 0x8000_0102 → HALT, `halt_cause`=01, outputs quiescent.
- Branch funct3=010 → HALT, `halt_cause`=10. Then hold `fetch_ready` low for 5 cycles during FETCH, then assert `rst_n` low mid-stall → `fetch_pc` stable throughout the stall, and reset values appear asynchronously.
- With `BRANCH_STATS_EN`: 3 taken and 2 not-taken branches → `taken_cnt`=3, `ntaken_cnt`=2; preload near saturation → counter sticks at 0xFFFF_FFFF.
